acm_table_sequencer: RTL and testbench

Walks the CoreABC ACM lookup table over a configurable address range. Each entry flagged valid (ACMDO=1) is forwarded to a downstream analog-configuration write port through a valid/ready handshake, and invalid entries are skipped. The block sits between the ACM table and the ACM configuration interface, and is started by the CoreABC control logic or a host register.

---
 rtl/acm_seq_pkg.sv | 28 ++
 rtl/acm_seq_watchdog.sv | 37 +++
 rtl/acm_table_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_acm_table_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acm_seq_pkg.sv
// Shared widths, default parameters, state encoding and counter helper for the ACM table sequencer.
package acm_seq_pkg;

  localparam int ACM_ADDR_W = 8;
  localparam int ACM_DATA_W = 8;
  localparam int WR_COUNT_W = 9;
  localparam int SETTLE_W   = 4;

  localparam int unsigned ADDR_FIRST_DEF     = 0;
  localparam int unsigned ADDR_LAST_DEF      = 255;
  localparam int unsigned SETTLE_DEF         = 1;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  localparam logic [WR_COUNT_W-1:0] WR_COUNT_MAX = 9'd256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } acm_seq_state_e;

  // Saturating write counter: a full 256-entry walk must read 256, never wrap.
  function automatic logic [WR_COUNT_W-1:0] wr_count_inc(input logic [WR_COUNT_W-1:0] v);
    return (v == WR_COUNT_MAX) ? v : v + WR_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/acm_seq_watchdog.sv
// Counts consecutive stalled write cycles and pulses expire_o on the cycle the stall reaches limit_i.
module acm_seq_watchdog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             ready_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  assign stall    = valid_i && !ready_i;
  assign expire_o = stall && (cnt_q == limit_i - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !stall || expire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/acm_table_sequencer.sv
// Walks the ACM lookup table and forwards valid entries to the configuration write port.
// Optional CFG_READY watchdog enabled by defining ACM_SEQ_TIMEOUT_EN.
module acm_table_sequencer
  import acm_seq_pkg::*;
#(
  parameter int unsigned ADDR_FIRST     = ADDR_FIRST_DEF,
  parameter int unsigned ADDR_LAST      = ADDR_LAST_DEF,
  parameter int unsigned SETTLE         = SETTLE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  PCLK,
  input  logic                  NSYSRESET,
  input  logic                  START,
  input  logic                  ABORT,
  output logic [ACM_ADDR_W-1:0] ACMADDR,
  input  logic [ACM_DATA_W-1:0] ACMDATA,
  input  logic                  ACMDO,
  output logic                  CFG_VALID,
  input  logic                  CFG_READY,
  output logic [ACM_ADDR_W-1:0] CFG_ADDR,
  output logic [ACM_DATA_W-1:0] CFG_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ABORTED,
  output logic                  TIMEOUT,
  output logic [WR_COUNT_W-1:0] WR_COUNT
);

  if (ADDR_LAST < ADDR_FIRST || ADDR_LAST > 255) begin : g_bad_range
    $error("acm_table_sequencer: ADDR_LAST must be >= ADDR_FIRST and <= 255");
  end
  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("acm_table_sequencer: SETTLE must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("acm_table_sequencer: TIMEOUT_CYCLES must be in 1..255");
  end

  localparam logic [ACM_ADDR_W-1:0] FIRST_A     = ACM_ADDR_W'(ADDR_FIRST);
  localparam logic [ACM_ADDR_W-1:0] LAST_A      = ACM_ADDR_W'(ADDR_LAST);
  localparam logic [SETTLE_W-1:0]   SETTLE_LAST = SETTLE_W'(SETTLE - 1);

  acm_seq_state_e        state_q, state_d;
  logic [ACM_ADDR_W-1:0] addr_q, addr_d;
  logic [SETTLE_W-1:0]   settle_q, settle_d;
  logic [ACM_ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [ACM_DATA_W-1:0] cfg_data_q, cfg_data_d;
  logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
  logic                  aborted_q, aborted_d;
  logic                  timeout_q, timeout_d;
  logic                  advance;
  logic                  stop;
  logic                  in_write;
  logic                  wd_expire;

  assign in_write = (state_q == ST_WRITE);

`ifdef ACM_SEQ_TIMEOUT_EN
  acm_seq_watchdog #(
    .CNT_W (8)
  ) u_watchdog (
    .clk      (PCLK),
    .rst_n    (NSYSRESET),
    .valid_i  (in_write),
    .ready_i  (CFG_READY),
    .clear_i  (!in_write),
    .limit_i  (8'(TIMEOUT_CYCLES)),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  // A watchdog expiry is handled exactly like an external abort.
  assign stop = ABORT || wd_expire;

  always_comb begin
    // NOTE: every next-state signal starts from its hold value so no path leaves it unassigned (no latch).
    state_d    = state_q;
    addr_d     = addr_q;
    settle_d   = settle_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    wr_count_d = wr_count_q;
    aborted_d  = aborted_q;
    timeout_d  = timeout_q;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (START && ABORT) begin
          aborted_d = 1'b1;
        end else if (START) begin
          addr_d     = FIRST_A;
          settle_d   = '0;
          wr_count_d = '0;
          aborted_d  = 1'b0;
          timeout_d  = 1'b0;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (stop) begin
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          cfg_addr_d = addr_q;
          cfg_data_d = ACMDATA;
          if (ACMDO) begin
            state_d = ST_WRITE;
          end else begin
            advance = 1'b1;
          end
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_WRITE: begin
        // Abort wins over a same-cycle handshake; that write is dropped uncounted.
        if (stop) begin
          aborted_d = 1'b1;
          timeout_d = timeout_q | wd_expire;
          state_d   = ST_IDLE;
        end else if (CFG_READY) begin
          wr_count_d = wr_count_inc(wr_count_q);
          advance    = 1'b1;
        end
      end
      ST_FINISH: begin
        if (ABORT) begin
          aborted_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Compare before incrementing so ADDR_LAST=255 terminates instead of wrapping.
    if (advance) begin
      if (addr_q == LAST_A) begin
        state_d = ST_FINISH;
      end else begin
        addr_d   = addr_q + ACM_ADDR_W'(1);
        settle_d = '0;
        state_d  = ST_LOOKUP;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
    if (!NSYSRESET) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      settle_q   <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      wr_count_q <= '0;
      aborted_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      settle_q   <= settle_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
      wr_count_q <= wr_count_d;
      aborted_q  <= aborted_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ACMADDR   = addr_q;
  assign CFG_VALID = in_write;
  assign CFG_ADDR  = cfg_addr_q;
  assign CFG_DATA  = cfg_data_q;
  assign BUSY      = (state_q == ST_LOOKUP) || in_write;
  assign DONE      = (state_q == ST_FINISH) && !ABORT;
  assign ABORTED   = aborted_q;
  assign TIMEOUT   = timeout_q;
  assign WR_COUNT  = wr_count_q;

endmodule

// File: tb/tb_acm_table_sequencer.sv
// Self-checking bench for acm_table_sequencer: directed scenarios plus a randomized walk
// compared against a cycle timeline built from the per-entry cost rules.
module tb_acm_table_sequencer;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic nrst;
  int   checks = 0;
  int   errors = 0;

  // Table model: data = ~addr, valid everywhere except address 100.
  logic [7:0] tbl_data [256];
  logic       tbl_vld  [256];
  logic [7:0] c_tdata  [256];
  logic       c_tvld   [256];

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       done;
  } step_t;

  step_t      tl[$];
  logic [15:0] exp_q[$];

  // ---------------- instance a: full range, SETTLE=1 ----------------
  logic       a_start, a_abort, a_ready, a_acmdo, a_cfg_valid, a_busy, a_done, a_aborted, a_timeout;
  logic [7:0] a_acmaddr, a_acmdata, a_cfg_addr, a_cfg_data;
  logic [8:0] a_wr_count;
  assign a_acmdata = tbl_data[a_acmaddr];
  assign a_acmdo   = tbl_vld[a_acmaddr];

  acm_table_sequencer #(.TIMEOUT_CYCLES(8)) u_dut_a (
    .PCLK(pclk), .NSYSRESET(nrst), .START(a_start), .ABORT(a_abort),
    .ACMADDR(a_acmaddr), .ACMDATA(a_acmdata), .ACMDO(a_acmdo),
    .CFG_VALID(a_cfg_valid), .CFG_READY(a_ready), .CFG_ADDR(a_cfg_addr), .CFG_DATA(a_cfg_data),
    .BUSY(a_busy), .DONE(a_done), .ABORTED(a_aborted), .TIMEOUT(a_timeout), .WR_COUNT(a_wr_count)
  );

  // ---------------- instance b: range 254..255 ----------------
  logic       b_start, b_abort, b_ready, b_acmdo, b_cfg_valid, b_busy, b_done, b_aborted, b_timeout;
  logic [7:0] b_acmaddr, b_acmdata, b_cfg_addr, b_cfg_data;
  logic [8:0] b_wr_count;
  assign b_acmdata = tbl_data[b_acmaddr];
  assign b_acmdo   = tbl_vld[b_acmaddr];

  acm_table_sequencer #(.ADDR_FIRST(254), .ADDR_LAST(255)) u_dut_b (
    .PCLK(pclk), .NSYSRESET(nrst), .START(b_start), .ABORT(b_abort),
    .ACMADDR(b_acmaddr), .ACMDATA(b_acmdata), .ACMDO(b_acmdo),
    .CFG_VALID(b_cfg_valid), .CFG_READY(b_ready), .CFG_ADDR(b_cfg_addr), .CFG_DATA(b_cfg_data),
    .BUSY(b_busy), .DONE(b_done), .ABORTED(b_aborted), .TIMEOUT(b_timeout), .WR_COUNT(b_wr_count)
  );

  // ---------------- instance c: range 10..40, SETTLE=3, random table ----------------
  logic       c_start, c_abort, c_ready, c_acmdo, c_cfg_valid, c_busy, c_done, c_aborted, c_timeout;
  logic [7:0] c_acmaddr, c_acmdata, c_cfg_addr, c_cfg_data;
  logic [8:0] c_wr_count;
  assign c_acmdata = c_tdata[c_acmaddr];
  assign c_acmdo   = c_tvld[c_acmaddr];

  acm_table_sequencer #(.ADDR_FIRST(10), .ADDR_LAST(40), .SETTLE(3)) u_dut_c (
    .PCLK(pclk), .NSYSRESET(nrst), .START(c_start), .ABORT(c_abort),
    .ACMADDR(c_acmaddr), .ACMDATA(c_acmdata), .ACMDO(c_acmdo),
    .CFG_VALID(c_cfg_valid), .CFG_READY(c_ready), .CFG_ADDR(c_cfg_addr), .CFG_DATA(c_cfg_data),
    .BUSY(c_busy), .DONE(c_done), .ABORTED(c_aborted), .TIMEOUT(c_timeout), .WR_COUNT(c_wr_count)
  );

  // Monitors: record handshakes and DONE pulses mid-cycle.
  logic [15:0] a_wq[$];
  logic [15:0] b_wq[$];
  int a_done_cnt = 0;
  int b_done_cnt = 0;
  int b_zero_cnt = 0;

  always @(negedge pclk) begin
    if (a_cfg_valid && a_ready) a_wq.push_back({a_cfg_addr, a_cfg_data});
    if (b_cfg_valid && b_ready) b_wq.push_back({b_cfg_addr, b_cfg_data});
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
    if ((b_busy || b_done) && b_acmaddr == 8'd0) b_zero_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=simulation still running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  function automatic logic [63:0] a_outs();
    return {26'd0, a_acmaddr, a_cfg_valid, a_cfg_addr, a_cfg_data, a_busy, a_done, a_aborted, a_timeout, a_wr_count};
  endfunction
  function automatic logic [63:0] b_outs();
    return {26'd0, b_acmaddr, b_cfg_valid, b_cfg_addr, b_cfg_data, b_busy, b_done, b_aborted, b_timeout, b_wr_count};
  endfunction
  function automatic logic [63:0] c_outs();
    return {26'd0, c_acmaddr, c_cfg_valid, c_cfg_addr, c_cfg_data, c_busy, c_done, c_aborted, c_timeout, c_wr_count};
  endfunction

  task automatic a_start_pulse();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_run_to_done(input int limit, output int n);
    n = 0;
    while (!a_done && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, nv, base_idx, done_base, zero_base, nwr, k;

    nrst = 1'b0;
    {a_start, a_abort, b_start, b_abort, c_start, c_abort} = '0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    c_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      tbl_data[i] = ~8'(i);
      tbl_vld[i]  = (i != 100);
      c_tdata[i]  = 8'($urandom_range(0, 255));
      c_tvld[i]   = ($urandom_range(0, 3) != 0);
    end

    // Reset state.
    tick(3);
    check("reset_a", a_outs(), 64'd0);
    check("reset_b", b_outs(), 64'd0);
    check("reset_c", c_outs(), 64'd0);
    nrst = 1'b1;
    tick();

    // START together with ABORT in IDLE: stay idle, flag the abort.
    a_start = 1'b1;
    a_abort = 1'b1;
    tick();
    a_start = 1'b0;
    a_abort = 1'b0;
    check("start_abort_busy", a_busy, 1'b0);
    check("start_abort_aborted", a_aborted, 1'b1);

    // Backpressure at address 3.
    a_start_pulse();
    check("start_clears_aborted", a_aborted, 1'b0);
    check("start_addr", a_acmaddr, 8'd0);
    check("start_busy", a_busy, 1'b1);
    n = 0;
    while (a_acmaddr != 8'd3 && n < 100) begin
      tick();
      n++;
    end
    check("bp_reach3", a_acmaddr, 8'd3);
    check("bp_count_before", a_wr_count, 9'd3);
    a_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) a_ready = 1'b1;
      check($sformatf("bp_valid_%0d", i), a_cfg_valid, 1'b1);
      check($sformatf("bp_addr_%0d", i), a_cfg_addr, 8'd3);
      check($sformatf("bp_data_%0d", i), a_cfg_data, 8'hFC);
      check($sformatf("bp_count_%0d", i), a_wr_count, 9'd3);
      tick();
    end
    check("bp_count_after", a_wr_count, 9'd4);
    check("bp_valid_after", a_cfg_valid, 1'b0);
    check("bp_addr_after", a_acmaddr, 8'd4);

    // ABORT in the WRITE cycle of address 50, with READY high.
    done_base = a_done_cnt;
    n = 0;
    while (!(a_cfg_valid && a_cfg_addr == 8'd50) && n < 300) begin
      tick();
      n++;
    end
    check("ab_reach50", {a_cfg_valid, a_cfg_addr}, {1'b1, 8'd50});
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("ab_busy", a_busy, 1'b0);
    check("ab_valid", a_cfg_valid, 1'b0);
    check("ab_aborted", a_aborted, 1'b1);
    check("ab_count", a_wr_count, 9'd50);
    tick(3);
    check("ab_no_done", a_done_cnt - done_base, 0);

    // Reset mid-walk, then restart from ADDR_FIRST and finish the walk.
    a_start_pulse();
    tick(20);
    nrst = 1'b0;
    tick();
    check("midreset_outs", a_outs(), 64'd0);
    nrst = 1'b1;
    base_idx = a_wq.size();
    done_base = a_done_cnt;
    a_start_pulse();
    check("restart_addr", a_acmaddr, 8'd0);
    check("restart_busy", a_busy, 1'b1);
    a_run_to_done(2000, n);
    check("full_cycles", n, 511);
    check("full_busy_at_done", a_busy, 1'b0);
    check("full_count", a_wr_count, 9'd255);
    tick();
    check("full_done_one_cycle", a_done, 1'b0);
    check("full_done_pulses", a_done_cnt - done_base, 1);
    check("full_count_hold", a_wr_count, 9'd255);
    exp_q.delete();
    for (int i = 0; i < 256; i++) if (tbl_vld[i]) exp_q.push_back({8'(i), tbl_data[i]});
    check("full_nwrites", a_wq.size() - base_idx, exp_q.size());
    for (int i = 0; i < exp_q.size() && base_idx + i < a_wq.size(); i++)
      check($sformatf("full_wr_%0d", i), a_wq[base_idx + i], exp_q[i]);

    // All-valid walk: 512 cycles, counter reaches 256.
    tbl_vld[100] = 1'b1;
    a_start_pulse();
    a_run_to_done(2000, n);
    check("allv_cycles", n, 512);
    check("allv_count", a_wr_count, 9'd256);
    tick();
    check("allv_count_hold", a_wr_count, 9'd256);
    tbl_vld[100] = 1'b0;

    // Two-entry range at the top of the table; mid-walk START is ignored.
    base_idx  = b_wq.size();
    done_base = b_done_cnt;
    zero_base = b_zero_cnt;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b_start_addr", b_acmaddr, 8'd254);
    check("b_start_busy", b_busy, 1'b1);
    n = 1;
    tick();
    b_start = 1'b1;
    n++;
    tick();
    b_start = 1'b0;
    while (!b_done && n < 50) begin
      tick();
      n++;
    end
    check("b_cycles", n, 4);
    check("b_done_addr", b_acmaddr, 8'd255);
    tick(4);
    check("b_done_pulses", b_done_cnt - done_base, 1);
    check("b_count", b_wr_count, 9'd2);
    check("b_busy_after", b_busy, 1'b0);
    check("b_no_wrap", b_zero_cnt - zero_base, 0);
    check("b_nwrites", b_wq.size() - base_idx, 2);
    if (b_wq.size() - base_idx == 2) begin
      check("b_wr_0", b_wq[base_idx], {8'd254, 8'h01});
      check("b_wr_1", b_wq[base_idx + 1], {8'd255, 8'h00});
    end

    // Randomized table and READY stalls against a timeline built from per-entry costs.
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 256; i++) begin
        c_tdata[i] = 8'($urandom_range(0, 255));
        c_tvld[i]  = ($urandom_range(0, 3) != 0);
      end
      tl.delete();
      nwr = 0;
      for (int a = 10; a <= 40; a++) begin
        for (int s = 0; s < 3; s++)
          tl.push_back('{addr: 8'(a), data: 8'd0, valid: 1'b0, ready: 1'($urandom_range(0, 1)), busy: 1'b1, done: 1'b0});
        if (c_tvld[a]) begin
          k = $urandom_range(0, 3);
          repeat (k) tl.push_back('{addr: 8'(a), data: c_tdata[a], valid: 1'b1, ready: 1'b0, busy: 1'b1, done: 1'b0});
          tl.push_back('{addr: 8'(a), data: c_tdata[a], valid: 1'b1, ready: 1'b1, busy: 1'b1, done: 1'b0});
          nwr++;
        end
      end
      tl.push_back('{addr: 8'd40, data: 8'd0, valid: 1'b0, ready: 1'($urandom_range(0, 1)), busy: 1'b0, done: 1'b1});
      c_start = 1'b1;
      tick();
      c_start = 1'b0;
      for (int j = 0; j < tl.size(); j++) begin
        c_ready = tl[j].ready;
        check($sformatf("rnd%0d_c%0d_addr", round, j), c_acmaddr, tl[j].addr);
        check($sformatf("rnd%0d_c%0d_ctl", round, j), {c_cfg_valid, c_busy, c_done}, {tl[j].valid, tl[j].busy, tl[j].done});
        if (tl[j].valid)
          check($sformatf("rnd%0d_c%0d_wr", round, j), {c_cfg_addr, c_cfg_data}, {tl[j].addr, tl[j].data});
        tick();
      end
      c_ready = 1'b0;
      check($sformatf("rnd%0d_count", round), c_wr_count, 9'(nwr));
      check($sformatf("rnd%0d_idle", round), {c_busy, c_done, c_cfg_valid}, 3'b000);
    end

    // READY held low forever.
    a_ready = 1'b0;
    done_base = a_done_cnt;
    a_start_pulse();
    tick();
`ifdef ACM_SEQ_TIMEOUT_EN
    nv = 0;
    n = 0;
    while (a_cfg_valid && n < 50) begin
      nv++;
      tick();
      n++;
    end
    check("to_valid_cycles", nv, 8);
    check("to_valid_dropped", a_cfg_valid, 1'b0);
    check("to_timeout", a_timeout, 1'b1);
    check("to_aborted", a_aborted, 1'b1);
    check("to_busy", a_busy, 1'b0);
    tick(2);
    check("to_no_done", a_done_cnt - done_base, 0);
    a_ready = 1'b1;
    a_start_pulse();
    check("to_cleared_by_start", {a_timeout, a_aborted}, 2'b00);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
`else
    tick(40);
    nv = 0;
    check("nto_valid", a_cfg_valid, 1'b1);
    check("nto_timeout", a_timeout, 1'b0);
    check("nto_count", a_wr_count, 9'd0);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("nto_abort_valid", a_cfg_valid, 1'b0);
    check("nto_abort_flag", a_aborted, 1'b1);
    check("nto_no_done", a_done_cnt - done_base, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
